// File: rtl/execution_pkg.sv
// Shared CPU definitions: ALU operation encodings, squash depth and the
// branch target helper used by the execute stage (and by instruction decode).
package execution_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_BEQ = 3'd5,
        ALU_BNE = 3'd6,
        ALU_J   = 3'd7
    } alu_op_e;

    // Number of younger instructions cancelled after a taken redirect.
    localparam logic [1:0] SQUASH_DEPTH = 2'd2;

    // Branch target: PC+4 plus the sign-extended word offset.
    function automatic logic [31:0] branch_target(input logic [31:0] npc,
                                                  input logic [15:0] imm);
        return npc + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/execution_alu.sv
// Combinational ALU: arithmetic/logic result plus a zero flag used for
// branch condition evaluation.
module ALU
    import execution_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUctr,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; beq/bne reuse the subtractor so zero means A == B.
    always_comb begin
        result = 32'd0;
        case (alu_op_e'(ALUctr))
            ALU_ADD: result = A + B;
            ALU_SUB: result = A - B;
            ALU_AND: result = A & B;
            ALU_OR:  result = A | B;
            ALU_SLT: result = {31'd0, ($signed(A) < $signed(B))};
            ALU_BEQ: result = A - B;
            ALU_BNE: result = A - B;
            ALU_J:   result = 32'd0;
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/execution.sv
// Execute stage: ALU, branch/jump resolution and the EX/MEM pipeline
// register. A taken redirect cancels the next two incoming instructions.
module execution
    import execution_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        branch,
    input  logic        jump,
    input  logic [2:0]  ALUctr,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] MD,
    input  logic [31:0] NPC,
    input  logic [31:0] JT,
    input  logic [31:0] DX_PC,
    input  logic [15:0] imm,
    input  logic [4:0]  RD,
    output logic        XM_MemtoReg,
    output logic        XM_RegWrite,
    output logic        XM_MemRead,
    output logic        XM_MemWrite,
    output logic [31:0] ALUout,
    output logic [31:0] XM_MD,
    output logic [4:0]  XM_RD,
    output logic        XM_redirect,
    output logic [31:0] XM_target,
    output logic        squash
);

    logic [31:0] alu_result;
    logic        alu_zero;
    logic        take_branch;
    logic        redirect_next;
    logic [31:0] target_next;
    logic [1:0]  squash_cnt_reg;
    logic        dx_pc_unused;

    // DX_PC travels with the instruction for tracing; nothing here consumes it.
    assign dx_pc_unused = ^DX_PC;

    ALU u_alu (
        .A      (A),
        .B      (B),
        .ALUctr (ALUctr),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign squash = (squash_cnt_reg != 2'd0);

    // Branch/jump resolution; a cancelled instruction never redirects.
    always_comb begin
        take_branch   = branch && (((alu_op_e'(ALUctr) == ALU_BEQ) && alu_zero) ||
                                   ((alu_op_e'(ALUctr) == ALU_BNE) && !alu_zero));
        redirect_next = (jump || take_branch) && !squash;
        target_next   = 32'd0;
        if (redirect_next)
            target_next = jump ? JT : branch_target(NPC, imm);
    end

    // EX/MEM register and squash counter; writes of cancelled instructions are masked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            XM_MemtoReg    <= 1'b0;
            XM_RegWrite    <= 1'b0;
            XM_MemRead     <= 1'b0;
            XM_MemWrite    <= 1'b0;
            ALUout         <= 32'd0;
            XM_MD          <= 32'd0;
            XM_RD          <= 5'd0;
            XM_redirect    <= 1'b0;
            XM_target      <= 32'd0;
            squash_cnt_reg <= 2'd0;
        end else begin
            XM_MemtoReg <= MemtoReg;
            XM_RegWrite <= RegWrite && !squash;
            XM_MemRead  <= MemRead && !squash;
            XM_MemWrite <= MemWrite && !squash;
            ALUout      <= alu_result;
            XM_MD       <= MD;
            XM_RD       <= RD;
            XM_redirect <= redirect_next;
            XM_target   <= target_next;
            if (redirect_next)
                squash_cnt_reg <= SQUASH_DEPTH;
            else if (squash_cnt_reg != 2'd0)
                squash_cnt_reg <= squash_cnt_reg - 2'd1;
        end
    end

endmodule

// File: tb/tb_execution.sv
// Self-checking bench for the execute stage: directed table, hand-written
// squash/jump/reset sequences and randomized stimulus against a reference model.
module tb_execution;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemtoReg, RegWrite, MemRead, MemWrite, branch, jump;
    logic [2:0]  ALUctr;
    logic [31:0] A, B, MD, NPC, JT, DX_PC;
    logic [15:0] imm;
    logic [4:0]  RD;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [31:0] ALUout, XM_MD;
    logic [4:0]  XM_RD;
    logic        XM_redirect;
    logic [31:0] XM_target;
    logic        squash;

    int n_checks = 0;
    int n_fail   = 0;
    int model_sq = 0;   // instructions still to be cancelled

    always #5 clk = ~clk;

    execution dut (
        .clk(clk), .rst(rst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .branch(branch), .jump(jump), .ALUctr(ALUctr),
        .A(A), .B(B), .MD(MD), .NPC(NPC), .JT(JT), .DX_PC(DX_PC),
        .imm(imm), .RD(RD),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
        .XM_redirect(XM_redirect), .XM_target(XM_target), .squash(squash)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU written directly from the operation definitions.
    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:       return 32'(a + b);
            1, 5, 6: return 32'(a - b);
            2:       return a & b;
            3:       return a | b;
            4:       return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        MemtoReg = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        branch = 0; jump = 0; ALUctr = 3'd0;
        A = 0; B = 0; MD = 0; NPC = 0; JT = 0; DX_PC = 0; imm = 0; RD = 0;
    endtask

    // Apply current inputs for one cycle and compare every output with the model.
    task automatic step(input string tag);
        bit          cancelled, taken;
        logic [31:0] e_alu, e_tgt;
        int          next_sq;
        cancelled = (model_sq != 0);
        taken = !cancelled && (jump || (branch && ((ALUctr == 3'd5 && A == B) ||
                                                   (ALUctr == 3'd6 && A != B))));
        e_alu = model_alu(int'(ALUctr), A, B);
        e_tgt = 32'd0;
        if (taken)
            e_tgt = jump ? JT : 32'(longint'(NPC) + longint'($signed(imm)) * 4);
        next_sq = taken ? 2 : (model_sq > 0 ? model_sq - 1 : 0);
        check({tag, ".squash_in"}, 32'(squash), 32'(cancelled));
        @(posedge clk); #1;
        check({tag, ".RegWrite"}, 32'(XM_RegWrite), 32'(RegWrite && !cancelled));
        check({tag, ".MemRead"},  32'(XM_MemRead),  32'(MemRead && !cancelled));
        check({tag, ".MemWrite"}, 32'(XM_MemWrite), 32'(MemWrite && !cancelled));
        check({tag, ".redirect"}, 32'(XM_redirect), 32'(taken));
        check({tag, ".target"},   XM_target, e_tgt);
        check({tag, ".squash"},   32'(squash), 32'(next_sq != 0));
        if (!cancelled) begin
            check({tag, ".ALUout"},   ALUout, e_alu);
            check({tag, ".MD"},       XM_MD, MD);
            check({tag, ".RD"},       32'(XM_RD), 32'(RD));
            check({tag, ".MemtoReg"}, 32'(XM_MemtoReg), 32'(MemtoReg));
        end
        $display("%s ctr=%0d A=%h B=%h -> ALUout=%h redir=%0b tgt=%h squash=%0b",
                 tag, ALUctr, A, B, ALUout, XM_redirect, XM_target, squash);
        model_sq = next_sq;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ALUout"},   ALUout, 32'd0);
        check({tag, ".MD"},       XM_MD, 32'd0);
        check({tag, ".RD"},       32'(XM_RD), 32'd0);
        check({tag, ".ctl"},      32'({XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}), 32'd0);
        check({tag, ".redirect"}, 32'(XM_redirect), 32'd0);
        check({tag, ".target"},   XM_target, 32'd0);
        check({tag, ".squash"},   32'(squash), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  ctr;
        logic [31:0] a, b;
        logic        br;
        logic [4:0]  rd;
        logic [31:0] exp_alu;
        logic        exp_redir;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd0, 32'h7FFFFFFF, 32'h1,        1'b0, 5'd5, 32'h80000000, 1'b0};
        vecs[1] = '{3'd4, 32'hFFFFFFFF, 32'h1,        1'b0, 5'd6, 32'h1,        1'b0};
        vecs[2] = '{3'd4, 32'h1,        32'hFFFFFFFF, 1'b0, 5'd7, 32'h0,        1'b0};
        vecs[3] = '{3'd1, 32'h5,        32'h7,        1'b0, 5'd8, 32'hFFFFFFFE, 1'b0};
        vecs[4] = '{3'd2, 32'hF0F0FFFF, 32'h0FF0F00F, 1'b0, 5'd9, 32'h00F0F00F, 1'b0};
        vecs[5] = '{3'd3, 32'hF0000000, 32'h0000000F, 1'b0, 5'd10, 32'hF000000F, 1'b0};
        vecs[6] = '{3'd6, 32'h4,        32'h4,        1'b1, 5'd11, 32'h0,       1'b0};
        vecs[7] = '{3'd7, 32'h1234,     32'h5678,     1'b0, 5'd12, 32'h0,       1'b0};

        idle();
        #12;
        check_all_zero("reset");
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        // Directed table, none of these redirect.
        for (int i = 0; i < 8; i++) begin
            idle();
            ALUctr = vecs[i].ctr; A = vecs[i].a; B = vecs[i].b;
            branch = vecs[i].br; RD = vecs[i].rd; RegWrite = 1;
            NPC = 32'h200;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_alu", i), ALUout, vecs[i].exp_alu);
            check($sformatf("vec%0d.tbl_redir", i), 32'(XM_redirect), 32'(vecs[i].exp_redir));
            check($sformatf("vec%0d.tbl_rd", i), 32'(XM_RD), 32'(vecs[i].rd));
        end

        // Taken beq, two cancelled followers, then a normal instruction.
        idle(); branch = 1; ALUctr = 3'd5; A = 3; B = 3; NPC = 32'h100; imm = 16'hFFFE;
        step("beq");
        check("beq.tgt_const", XM_target, 32'hF8);
        for (int i = 0; i < 3; i++) begin
            idle(); RegWrite = 1; MemWrite = 1; MemRead = 1; ALUctr = 3'd0; A = 10; B = i; RD = 5'(i + 1);
            step($sformatf("beq_follow%0d", i));
            check($sformatf("beq_follow%0d.wr", i), 32'(XM_RegWrite), (i == 2) ? 32'd1 : 32'd0);
        end

        // Jump followed by a store that must be cancelled.
        idle(); jump = 1; ALUctr = 3'd7; JT = 32'h40;
        step("jump");
        check("jump.tgt_const", XM_target, 32'h40);
        idle(); MemWrite = 1; ALUctr = 3'd0; A = 32'h80; B = 4; MD = 32'hCAFE;
        step("sw");
        check("sw.memwrite_const", 32'(XM_MemWrite), 32'd0);
        idle(); step("drain0");
        idle(); step("drain1");

        // Reset one cycle after a redirect abandons the squash.
        idle(); jump = 1; JT = 32'h80; ALUctr = 3'd7;
        step("rjump");
        idle(); RegWrite = 1;
        step("rnext");
        #2 rst = 0;
        #1 check_all_zero("midreset");
        @(negedge clk); rst = 1;
        model_sq = 0;
        @(posedge clk); #1;
        idle(); RegWrite = 1; ALUctr = 3'd0; A = 2; B = 3; RD = 5'd4;
        step("post_rst_add");
        check("post_rst_add.alu_const", ALUout, 32'd5);

        // Randomized stimulus.
        for (int i = 0; i < 300; i++) begin
            idle();
            ALUctr = 3'($urandom_range(0, 7));
            A = $urandom; B = ($urandom_range(0, 3) == 0) ? A : $urandom;
            MD = $urandom; NPC = $urandom; JT = $urandom; imm = 16'($urandom); RD = 5'($urandom);
            MemtoReg = 1'($urandom); RegWrite = 1'($urandom);
            MemRead = 1'($urandom); MemWrite = 1'($urandom);
            branch = ($urandom_range(0, 2) == 0);
            jump = ($urandom_range(0, 7) == 0);
            step($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execution.md
EXECUTION -- requirements
Module: EXECUTION

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset. While rst is 0, all registers hold their reset values.
REQ-003 SHALL have decode-side control inputs, each 1 bit: MemtoReg, RegWrite, MemRead, MemWrite, branch, jump.
REQ-004 SHALL have input ALUctr, 3 bits. Encoding: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 beq, 6 bne, 7 j.
REQ-005 SHALL have 32-bit operand inputs: A, B, MD (store data), NPC (PC+4 of the instruction), JT (jump target), DX_PC.
REQ-006 SHALL have inputs imm, 16 bits, and RD, 5 bits.
REQ-007 SHALL have registered 1-bit control outputs: XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite.
REQ-008 SHALL have registered data outputs: ALUout (32 bits), XM_MD (32 bits), XM_RD (5 bits).
REQ-009 SHALL have registered redirect outputs: XM_redirect (1 bit, taken branch or jump) and XM_target (32 bits).
REQ-010 SHALL have output squash, 1 bit: high while the incoming instruction is being cancelled.

Function
REQ-011 SHALL register every output with exactly 1 cycle of latency from its inputs.
REQ-012 SHALL compute ALUout as follows:
- add: A+B; sub: A-B; and: A&B; or: A|B.
- All results are 32-bit and wrap modulo 2^32; no overflow trap.
REQ-013 SHALL compute slt as a signed two's-complement compare: ALUout = 1 if A<B, else 0.
REQ-014 SHALL set ALUout = A-B for beq and bne.
REQ-015 SHALL set ALUout = 0 for j and for any undefined ALUctr.
REQ-016 SHALL take a branch when:
- branch=1 and ALUctr=5 and A==B, or
- branch=1 and ALUctr=6 and A!=B.
REQ-017 SHALL compute the branch target as NPC + (sign-extended imm << 2), modulo 2^32.
REQ-018 SHALL, when jump=1, set XM_redirect=1 and XM_target=JT. Jump has priority if branch is also set.
REQ-019 SHALL hold XM_target at 0 when no redirect occurs.
REQ-020 SHALL pass MD to XM_MD and RD to XM_RD unchanged.
REQ-021 SHALL keep a 2-bit squash counter:
- Loads 2 on the same edge that registers XM_redirect=1.
- Otherwise decrements by 1 per cycle while nonzero.
- squash = (counter != 0).
REQ-022 SHALL, while squash=1, force the registered XM_RegWrite, XM_MemRead, XM_MemWrite and XM_redirect to 0 and leave data outputs don't-care. Squashed branches and jumps never redirect.
REQ-023 SHALL give a new redirect precedence over decrement. Because of REQ-022, this case cannot arise while squash=1.

Reset
REQ-024 SHALL, on rst=0, drive all outputs to 0 and clear the squash counter to 0, independent of clk.
REQ-025 SHALL, when reset is asserted mid-squash, abandon the squash. The first instruction after release is executed normally.

Structure
REQ-026 SHALL place the ALUctr encodings and the squash depth constant (2) in the shared CPU package, also used by INSTRUCTION_DECODE.
REQ-027 SHALL implement the arithmetic in a combinational sub-module ALU (inputs A, B, ALUctr; outputs result, zero). EXECUTION holds all registers.

Verification
REQ-028 SHALL cover: add with A=32'h7FFFFFFF, B=1, RegWrite=1, RD=5 -> next cycle ALUout=32'h80000000, XM_RegWrite=1, XM_RD=5.
REQ-029 SHALL cover: slt with A=32'hFFFFFFFF, B=1 -> ALUout=1. Then A=1, B=32'hFFFFFFFF -> ALUout=0.
REQ-030 SHALL cover: beq with A=B=3, NPC=32'h100, imm=16'hFFFE -> XM_redirect=1, XM_target=32'hF8. The next two cycles show squash=1 with all incoming writes suppressed; the third cycle is normal.
REQ-031 SHALL cover: bne with A=B=4 -> XM_redirect=0, XM_target=0, and no squash.
REQ-032 SHALL cover: jump=1, JT=32'h40, while the following instruction is sw -> redirect to 32'h40, and that sw's XM_MemWrite=0.
REQ-033 SHALL cover: rst pulled low one cycle after a redirect -> all outputs 0 immediately. After release, an add executes with squash=0.
